// File: rtl/fixed2uint_stream_if.sv
// Stream bundle between the PE array output, the fixed->uint converter and the frame writer.
// The slave side is the converter; the master side is its environment.
interface fixed2uint_stream_if #(
    parameter int width_uint  = 8,
    parameter int width_fixed = 15,
    parameter int col_w       = 6,
    parameter int row_w       = 6,
    parameter int width_sat   = 16
);
    logic                          frame_start;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [width_fixed-1:0] fixed;
    logic                          out_valid;
    logic                          out_ready;
    logic [width_uint-1:0]         gray;
    logic [col_w-1:0]              out_col;
    logic [row_w-1:0]              out_row;
    logic                          out_eol;
    logic                          out_eof;
    logic [width_sat-1:0]          sat_count;

    modport slave (
        input  frame_start, in_valid, fixed, out_ready,
        output in_ready, out_valid, gray, out_col, out_row, out_eol, out_eof, sat_count
    );

    modport master (
        output frame_start, in_valid, fixed, out_ready,
        input  in_ready, out_valid, gray, out_col, out_row, out_eol, out_eof, sat_count
    );
endinterface

// File: rtl/fixed2uint_stream.sv
// CeNN output stage: converts signed fixed-point cell outputs to gray pixels, gray = (1 - x)*128,
// over a 3-stage stall-able pipeline that tags position and counts clamped pixels per frame.
module fixed2uint_stream #(
    parameter int width_uint        = 8,
    parameter int width_fixed       = 15,
    parameter int position_int_part = 10,
    parameter int img_width         = 64,
    parameter int img_height        = 64,
    parameter int width_sat         = 16
) (
    input logic               clk,
    input logic               rst_n,
    fixed2uint_stream_if.slave strm
);
    localparam int COL_W  = (img_width > 1) ? $clog2(img_width) : 1;
    localparam int ROW_W  = (img_height > 1) ? $clog2(img_height) : 1;
    localparam int STAGES = 3;
    localparam int DW     = width_fixed + 2;
    // scale 2^(position_int_part-1) down to 2^(width_uint-1)
    localparam int SHIFT  = position_int_part - width_uint;

    localparam logic signed [DW-1:0] ONE  = DW'(1 << (position_int_part - 1));
    localparam logic signed [DW-1:0] RND  = DW'(1 << (SHIFT - 1));
    localparam logic signed [DW-1:0] UMAX = DW'((1 << width_uint) - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(img_width - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(img_height - 1);

    logic [STAGES:1]        vld_pipe;
    logic                   rdy_q;
    logic                   advance;
    logic                   accept;
    logic                   xfer;
    logic signed [DW-1:0]   d_s1;
    logic signed [DW-1:0]   r_rnd;
    logic signed [DW-1:0]   r_s2;
    logic [width_uint-1:0]  clamp_s2;
    logic                   sat_s2;
    logic [width_uint-1:0]  gray_q;
    logic                   sat_q;
    logic [COL_W-1:0]       col_q;
    logic [ROW_W-1:0]       row_q;
    logic [width_sat-1:0]   sat_cnt_q;
    logic                   first_px;

    always_comb begin
        advance  = strm.out_ready | ~vld_pipe[STAGES];
        accept   = strm.in_valid & rdy_q & advance;
        xfer     = vld_pipe[STAGES] & strm.out_ready;
        r_rnd    = d_s1 + RND;
        first_px = (col_q == '0) && (row_q == '0);
    end

    always_comb begin
        sat_s2   = 1'b0;
        clamp_s2 = r_s2[width_uint-1:0];
        if (r_s2[DW-1]) begin
            clamp_s2 = '0;
            sat_s2   = 1'b1;
        end else if (r_s2 > UMAX) begin
            clamp_s2 = '1;
            sat_s2   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q     <= 1'b0;
            vld_pipe  <= '0;
            d_s1      <= '0;
            r_s2      <= '0;
            gray_q    <= '0;
            sat_q     <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            sat_cnt_q <= '0;
        end else begin
            // holds in_ready low for the first cycle after reset release
            rdy_q <= 1'b1;
            if (strm.frame_start) begin
                vld_pipe  <= '0;
                col_q     <= '0;
                row_q     <= '0;
                sat_cnt_q <= '0;
            end else begin
                if (advance) vld_pipe <= {vld_pipe[STAGES-1:1], accept};
                if (xfer) begin
                    if (col_q == COL_LAST) begin
                        col_q <= '0;
                        row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                    // the first pixel of a frame drops the previous frame's total and restarts from its own flag
                    if (first_px) sat_cnt_q <= width_sat'(sat_q);
                    else if (sat_q && !(&sat_cnt_q)) sat_cnt_q <= sat_cnt_q + 1'b1;
                end
            end
            if (advance) begin
                d_s1   <= ONE - DW'(strm.fixed);
                r_s2   <= r_rnd >>> SHIFT;
                gray_q <= clamp_s2;
                sat_q  <= sat_s2;
            end
        end
    end

    assign strm.in_ready  = rdy_q & advance;
    assign strm.out_valid = vld_pipe[STAGES];
    assign strm.gray      = gray_q;
    assign strm.out_col   = col_q;
    assign strm.out_row   = row_q;
    assign strm.out_eol   = vld_pipe[STAGES] & (col_q == COL_LAST);
    assign strm.out_eof   = vld_pipe[STAGES] & (col_q == COL_LAST) & (row_q == ROW_LAST);
    assign strm.sat_count = sat_cnt_q;
endmodule

// File: tb/tb_fixed2uint_stream.sv
// Bench for fixed2uint_stream on a 4x2 frame with a 2-bit saturation counter.
module tb_fixed2uint_stream;
    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int SAT_W = 2;
    localparam int SAT_MAX = (1 << SAT_W) - 1;

    typedef struct packed {
        logic [7:0] g;
        logic       s;
    } exp_t;

    typedef struct {
        logic signed [14:0] fx;
        logic [7:0]         g;
        logic               s;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    exp_t cur_exp;
    exp_t sb[$];
    int   mcol, mrow, msat, out_cnt;
    logic stall_prev;
    logic [7:0] prev_gray;
    logic [1:0] prev_col;
    logic       prev_row;
    vec_t tbl[9];

    fixed2uint_stream_if #(.width_uint(8), .width_fixed(15), .col_w(2), .row_w(1), .width_sat(SAT_W)) bus ();

    fixed2uint_stream #(
        .width_uint(8), .width_fixed(15), .position_int_part(10),
        .img_width(IMG_W), .img_height(IMG_H), .width_sat(SAT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .strm (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // gray = (1 - x/512)*128, rounded half up, clamped to 0..255
    function automatic exp_t ref_conv(input int x);
        real  v;
        exp_t e;
        v = $floor((512.0 - real'(x)) / 4.0 + 0.5);
        if (v < 0.0)        e = '{g: 8'd0,   s: 1'b1};
        else if (v > 255.0) e = '{g: 8'd255, s: 1'b1};
        else                e = '{g: 8'(int'(v)), s: 1'b0};
        return e;
    endfunction

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic signed [14:0] fx, input exp_t e);
        logic acc;
        int   t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.fixed    = fx;
        cur_exp      = e;
        forever begin
            @(negedge clk);
            acc = bus.in_ready && !bus.frame_start && rst_n;
            @(posedge clk);
            #1;
            if (acc) break;
            t++;
            if (t > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: got no accept, expected accept within 200 cycles");
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_lat(input vec_t v);
        send(v.fx, '{g: v.g, s: v.s});
        @(negedge clk); chk("lat_s1_valid", int'(bus.out_valid), 0);
        @(negedge clk); chk("lat_s2_valid", int'(bus.out_valid), 0);
        @(negedge clk); chk("lat_s3_valid", int'(bus.out_valid), 1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_fs();
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue_empty", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // scoreboard / position model
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            mcol = 0; mrow = 0; msat = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", int'(bus.out_valid), 1);
                chk("hold_gray", int'(bus.gray), int'(prev_gray));
                chk("hold_col", int'(bus.out_col), int'(prev_col));
                chk("hold_row", int'(bus.out_row), int'(prev_row));
            end
            if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", int'(bus.in_ready), 0);
            if (!bus.out_valid) begin
                chk("idle_eol", int'(bus.out_eol), 0);
                chk("idle_eof", int'(bus.out_eof), 0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got pixel gray=%0d, expected none", bus.gray);
                end else begin
                    e = sb.pop_front();
                    chk("gray", int'(bus.gray), int'(e.g));
                    chk("col", int'(bus.out_col), mcol);
                    chk("row", int'(bus.out_row), mrow);
                    chk("eol", int'(bus.out_eol), int'(mcol == IMG_W - 1));
                    chk("eof", int'(bus.out_eof), int'(mcol == IMG_W - 1 && mrow == IMG_H - 1));
                    chk("sat_count", int'(bus.sat_count), msat);
                    if (!bus.frame_start) begin
                        if (mcol == 0 && mrow == 0) msat = int'(e.s);
                        else if (e.s && msat < SAT_MAX) msat++;
                        if (mcol == IMG_W - 1) begin
                            mcol = 0;
                            mrow = (mrow == IMG_H - 1) ? 0 : mrow + 1;
                        end else begin
                            mcol++;
                        end
                    end
                    out_cnt++;
                end
            end
            if (bus.frame_start) begin
                sb.delete();
                mcol = 0; mrow = 0; msat = 0;
            end else if (bus.in_valid && bus.in_ready) begin
                sb.push_back(cur_exp);
            end
            stall_prev = bus.out_valid && !bus.out_ready && !bus.frame_start;
            prev_gray  = bus.gray;
            prev_col   = bus.out_col;
            prev_row   = bus.out_row;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0; n_bad = 0; out_cnt = 0;
        bus.in_valid = 1'b0; bus.fixed = '0; bus.out_ready = 1'b1; bus.frame_start = 1'b0;
        cur_exp = '0;
        rst_n = 1'b0;

        tbl[0] = '{fx:  15'sd512,   g: 8'd0,   s: 1'b0};
        tbl[1] = '{fx:  15'sd0,     g: 8'd128, s: 1'b0};
        tbl[2] = '{fx:  15'sd1,     g: 8'd128, s: 1'b0};
        tbl[3] = '{fx:  15'sd3,     g: 8'd127, s: 1'b0};
        tbl[4] = '{fx: -15'sd508,   g: 8'd255, s: 1'b0};
        tbl[5] = '{fx: -15'sd512,   g: 8'd255, s: 1'b1};
        tbl[6] = '{fx:  15'sd1000,  g: 8'd0,   s: 1'b1};
        tbl[7] = '{fx: -15'sd16384, g: 8'd255, s: 1'b1};
        tbl[8] = '{fx:  15'sd4,     g: 8'd127, s: 1'b0};

        // reset state
        #12;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_gray", int'(bus.gray), 0);
        chk("rst_col", int'(bus.out_col), 0);
        chk("rst_row", int'(bus.out_row), 0);
        chk("rst_sat", int'(bus.sat_count), 0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", int'(bus.in_ready), 1);

        // conversion table, one at a time with latency check
        for (int i = 0; i < 5; i++) send_lat(tbl[i]);
        drain();
        chk("conv_sat_count", int'(bus.sat_count), 0);

        // saturation, back-to-back in a fresh frame
        pulse_fs();
        for (int i = 5; i < 9; i++) send(tbl[i].fx, '{g: tbl[i].g, s: tbl[i].s});
        drain();
        chk("sat_count_3", int'(bus.sat_count), 3);

        // backpressure: 10 ramp samples with a 5-cycle stall mid-stream
        pulse_fs();
        fork
            for (int i = 0; i < 10; i++) send(15'(-400 + 40 * i), ref_conv(-400 + 40 * i));
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // frame tagging: 9 pixels, pixel 1 saturates, 9th starts the next frame
        pulse_fs();
        for (int i = 0; i < 9; i++) begin
            if (i == 1) send(-15'sd600, ref_conv(-600));
            else        send(15'(-200 + 8 * i), ref_conv(-200 + 8 * i));
        end
        drain();
        chk("frame_next_sat_cleared", int'(bus.sat_count), 0);

        // frame_start mid-frame with a full pipeline
        pulse_fs();
        fork
            for (int i = 0; i < 8; i++) send(-15'sd600, ref_conv(-600));
            begin
                int base, t;
                base = out_cnt;
                t = 0;
                while (out_cnt < base + 5 && t < 200) begin
                    @(posedge clk); #1;
                    t++;
                end
                chk("fs_pixels_before", int'(out_cnt >= base + 5), 1);
                pulse_fs();
                chk("fs_out_valid", int'(bus.out_valid), 0);
                chk("fs_sat_count", int'(bus.sat_count), 0);
                chk("fs_col", int'(bus.out_col), 0);
                chk("fs_row", int'(bus.out_row), 0);
            end
        join
        drain();

        // async reset mid-stream
        for (int i = 0; i < 3; i++) send(15'(100 * i), ref_conv(100 * i));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(bus.out_valid), 0);
        chk("arst_in_ready", int'(bus.in_ready), 0);
        chk("arst_gray", int'(bus.gray), 0);
        chk("arst_col", int'(bus.out_col), 0);
        chk("arst_row", int'(bus.out_row), 0);
        chk("arst_sat", int'(bus.sat_count), 0);
        #10 rst_n = 1'b1;
        #1;
        chk("arst_ready_release", int'(bus.in_ready), 0);
        @(posedge clk); #1;
        chk("arst_ready_next", int'(bus.in_ready), 1);
        send_lat('{fx: 15'sd256, g: 8'd64, s: 1'b0});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fixed2uint_stream.md
Name: fixed2uint_stream

Overview:
- Output stage of the CeNN datapath. Consumes the 15-bit fixed-point cell outputs produced by the PE array and converts each back to an 8-bit gray pixel.
- Conversion is gray = (1 - x)*128, rounded and clamped. It is the exact inverse of the input pixel-to-fixed mapping.
- Provides a valid/ready stream with backpressure toward the frame writer.
- Tags each pixel with row/column position and end-of-line/end-of-frame flags.
- Counts saturated pixels per frame.

Parameters:
- width_uint, 8, output pixel width
- width_fixed, 15, input fixed-point width (two's complement, 9 fractional bits; 1.0 = 512)
- position_int_part, 10, bit index where the int part starts; sets the scale 2^(position_int_part-1) = 512
- img_width, 64, pixels per line
- img_height, 64, lines per frame
- width_sat, 16, saturation counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  synchronous pulse; flushes pipeline and clears counters
- in_valid  in  1  fixed sample valid
- in_ready  out  1  block accepts sample this cycle
- fixed  in  width_fixed  signed cell output
- out_valid  out  1  pixel valid
- out_ready  in  1  downstream accepts pixel
- gray  out  width_uint  converted pixel
- out_col  out  clog2(img_width)  column of current pixel
- out_row  out  clog2(img_height)  row of current pixel
- out_eol  out  1  current pixel is last in line
- out_eof  out  1  current pixel is last in frame
- sat_count  out  width_sat  pixels clamped in current frame

Behaviour:
- Reset (rst_n low, async): all outputs 0, pipeline valid bits 0, counters 0. in_ready is 1 one cycle after release.
- Pipeline of 3 register stages:
  - S1: d = 512 - fixed, 17-bit signed.
  - S2: r = (d + 2) >>> 2, arithmetic shift (round half up).
  - S3: clamp. r < 0 -> 0 with sat flag; r > 255 -> 255 with sat flag; else r[7:0].
- Transfer rules:
  - Input transfer occurs on in_valid & in_ready; output transfer on out_valid & out_ready.
  - advance = out_ready | ~out_valid. All stages shift together on advance. Bubbles propagate and are not collapsed.
  - in_ready = advance, a combinational path from out_ready.
- Latency: 3 cycles from accepted input to out_valid when out_ready is held 1. Throughput is 1 pixel/cycle.
- Stall: while out_valid & ~out_ready, gray, flags and position are held stable and no stage changes.
- Position counters:
  - Attached in S3 and advance on each output transfer. col increments; at col = img_width-1, col wraps to 0 and row increments.
  - At the last pixel (row = img_height-1, col = img_width-1), both wrap to 0.
  - out_eol = (col == img_width-1). out_eof = out_eol & (row == img_height-1).
  - Both are qualified by out_valid and are 0 otherwise.
- sat_count:
  - Increments on each output transfer whose sat flag is set; saturates at all-ones with no wrap.
  - Holds its value through the eof transfer.
  - Clears to 0 on the transfer after eof, and on frame_start.
- frame_start:
  - Clears all pipeline valid bits, col, row and sat_count next cycle. An input presented in the same cycle is dropped.
  - Has priority over simultaneous input or output transfers; the output transfer still completes for downstream, but is not counted.
- Rounding is irrelevant for values produced by the input stage, which are multiples of 4 offset from 512. Round-trip gray -> fixed -> gray is an identity for 0..255.

Test Plan:
- Conversion table, out_ready=1:
  - fixed = 512 -> gray 0; 0 -> 128; 1 -> 128; 3 -> 127; -508 -> 255.
  - Each appears 3 cycles after acceptance; sat_count stays 0.
- Saturation:
  - fixed = -512 -> 255; fixed = 1000 -> 0; fixed = -16384 -> 255.
  - sat_count reaches 3; the in-range neighbour fixed = 4 -> 127 does not increment it.
- Backpressure:
  - Stream 10 ramped samples; hold out_ready=0 for 5 cycles mid-stream.
  - Required: in_ready=0 during the stall, gray held stable, no sample lost or duplicated, order preserved.
- Frame tagging with img_width=4, img_height=2:
  - Stream 8 samples. out_eol is asserted on pixels 3 and 7; out_eof only on pixel 7.
  - The 9th pixel reports col 0, row 0; sat_count clears on it.
- frame_start mid-frame:
  - After 5 pixels with pipeline full, pulse frame_start.
  - Required: out_valid=0 next cycle, the next accepted pixel reports col 0 / row 0, sat_count=0.
- Async reset mid-stream:
  - Assert rst_n low between clock edges. All outputs are 0 immediately.
  - After release, the first sample emerges with position 0/0 after 3 cycles.
